// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef logic port_id_t;

  localparam port_id_t PORT_CPU = 1'b0;
  localparam port_id_t PORT_LD  = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between CPU and loader requests.
// DMEM_ARB_RR_EN selects round-robin on ties; otherwise CPU has fixed priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic     cpu_req_i,
  input  logic     ld_req_i,
`ifdef DMEM_ARB_RR_EN
  input  port_id_t last_grant_i,
`endif
  output logic     win_vld_c_o,
  output port_id_t win_id_c_o
);

  always_comb begin
    win_vld_c_o = cpu_req_i | ld_req_i;
    win_id_c_o  = PORT_CPU;
    if (cpu_req_i && ld_req_i) begin
`ifdef DMEM_ARB_RR_EN
      // On a tie the port that lost last time wins.
      win_id_c_o = (last_grant_i == PORT_CPU) ? PORT_LD : PORT_CPU;
`else
      win_id_c_o = PORT_CPU;
`endif
    end else if (ld_req_i) begin
      win_id_c_o = PORT_LD;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter/sequencer for CPU MEM stage and loader.
// Build option: define DMEM_ARB_RR_EN for round-robin tie-breaking (default: CPU priority).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wData,
  output logic [DATA_W-1:0] o_cpu_rData,
  output logic              o_cpu_ack,
  output logic              o_cpu_stall,
  input  logic              i_ld_req,
  input  logic              i_ld_we,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_wData,
  output logic [DATA_W-1:0] o_ld_rData,
  output logic              o_ld_ack,
  output logic              o_DMem_we,
  output logic [ADDR_W-1:0] o_DMem_addr,
  output logic [DATA_W-1:0] o_DMem_wData,
  input  logic [DATA_W-1:0] i_DMem_rData
);

  if (WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_arbiter: WAIT_CYCLES must be in 0..15");
  end

  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_CYCLES);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  port_id_t            id_q, id_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wstb_q, wstb_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                ld_ack_q, ld_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   ld_rdata_q, ld_rdata_d;
  logic                win_vld;
  port_id_t            win_id;
`ifdef DMEM_ARB_RR_EN
  port_id_t            last_grant_q, last_grant_d;
`endif

  dmem_arb_pick u_pick (
    .cpu_req_i    (i_cpu_req),
    .ld_req_i     (i_ld_req),
`ifdef DMEM_ARB_RR_EN
    .last_grant_i (last_grant_q),
`endif
    .win_vld_c_o  (win_vld),
    .win_id_c_o   (win_id)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      id_q        <= PORT_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstb_q      <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ld_ack_q    <= 1'b0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
`ifdef DMEM_ARB_RR_EN
      last_grant_q <= PORT_LD;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstb_q      <= wstb_d;
      cpu_ack_q   <= cpu_ack_d;
      ld_ack_q    <= ld_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
`ifdef DMEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstb_d      = 1'b0;
    cpu_ack_d   = 1'b0;
    ld_ack_d    = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;
`ifdef DMEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          id_d    = win_id;
          we_d    = (win_id == PORT_LD) ? i_ld_we     : i_cpu_we;
          addr_d  = (win_id == PORT_LD) ? i_ld_addr   : i_cpu_addr;
          wdata_d = (win_id == PORT_LD) ? i_ld_wData  : i_cpu_wData;
          // Strobe is registered so it lands in the first ACCESS cycle only.
          wstb_d  = (win_id == PORT_LD) ? i_ld_we     : i_cpu_we;
          cnt_d   = WAIT_CNT;
          state_d = ACCESS;
`ifdef DMEM_ARB_RR_EN
          last_grant_d = win_id;
`endif
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = RESP;
          if (id_q == PORT_CPU) begin
            cpu_rdata_d = i_DMem_rData;
            cpu_ack_d   = 1'b1;
          end else begin
            ld_rdata_d = i_DMem_rData;
            ld_ack_d   = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset in the strobe cycle must keep the write from reaching memory.
  assign o_DMem_we    = wstb_q & ~rst;
  assign o_DMem_addr  = addr_q;
  assign o_DMem_wData = wdata_q;
  assign o_cpu_ack    = cpu_ack_q;
  assign o_ld_ack     = ld_ack_q;
  assign o_cpu_rData  = cpu_rdata_q;
  assign o_ld_rData   = ld_rdata_q;
  assign o_cpu_stall  = i_cpu_req & ~cpu_ack_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and access sequencer for the single-port data memory. It shares that memory between two requesters: the pipeline MEM stage (CPU port) and the program/debug loader (LD port). It serialises their accesses and inserts a configurable number of wait states. It also generates the stall that freezes the pipeline while the CPU port is waiting. It sits between the MEM stage registers and the DataMemory instance.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- WAIT_CYCLES, 1, extra memory wait states per access (0..15)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_cpu_req  in  1  CPU access request (level, held until ack)
- i_cpu_we  in  1  CPU write enable (1 = write, 0 = read)
- i_cpu_addr  in  ADDR_W  CPU address
- i_cpu_wData  in  DATA_W  CPU write data
- o_cpu_rData  out  DATA_W  CPU read data, valid while o_cpu_ack
- o_cpu_ack  out  1  CPU access complete, one-cycle pulse
- o_cpu_stall  out  1  pipeline stall, = i_cpu_req & ~o_cpu_ack
- i_ld_req, i_ld_we, i_ld_addr, i_ld_wData  in  1/1/ADDR_W/DATA_W  loader request, same semantics as CPU
- o_ld_rData, o_ld_ack  out  DATA_W/1  loader response, same semantics as CPU
- o_DMem_we  out  1  memory write strobe
- o_DMem_addr  out  ADDR_W  memory address
- o_DMem_wData  out  DATA_W  memory write data
- i_DMem_rData  in  DATA_W  memory read data, valid one cycle after address is presented

## Operation
- FSM states are IDLE, ACCESS and RESP.
- **IDLE**
  - If any req is high: pick the winner.
  - Latch the winner's we/addr/wData and the winner ID.
  - Load cnt := WAIT_CYCLES and go to ACCESS.
  - With no req, stay in IDLE.
- **ACCESS**
  - o_DMem_addr and o_DMem_wData are driven from the latched registers.
  - o_DMem_we = latched_we & (cnt == WAIT_CYCLES), i.e. exactly one write pulse per write.
  - While cnt != 0: decrement cnt.
  - When cnt == 0: capture i_DMem_rData into the read-data register (also for writes) and go to RESP.
- **RESP**
  - Assert ack to the latched winner only; the other ack stays 0.
  - Drive that port's rData from the read-data register; the non-winner rData holds its previous value.
  - Go to IDLE.
- Requester rule: req must be low in the cycle after ack unless a new transaction is intended. A req sampled high in IDLE is always a new access.
- Requester rule: we/addr/wData must be stable from req rise until ack. The arbiter latches them anyway, so later changes do not affect the access in flight.
- Arbitration with both req high in IDLE is set by DMEM_ARB_RR_EN (see Configuration).
- A request arriving during ACCESS or RESP waits; no preemption.
- In IDLE and RESP: o_DMem_we = 0, and o_DMem_addr/o_DMem_wData hold their last latched values.

## Timing
- Reset values:
  - state = IDLE, cnt = 0, all latches = 0, last_grant = LD.
  - o_cpu_ack = o_ld_ack = 0, o_cpu_rData = o_ld_rData = 0.
  - o_DMem_we = 0, o_DMem_addr = 0, o_DMem_wData = 0.
  - o_cpu_stall = i_cpu_req.
- Latency: req sampled in IDLE at cycle T; ack is high in cycle T + WAIT_CYCLES + 2.
- Throughput: one access per WAIT_CYCLES + 3 cycles.
- Write strobe is high in cycle T+1 only.
- Reset mid-ACCESS:
  - The FSM returns to IDLE on the next edge.
  - If the write strobe has not yet occurred, it is suppressed.
  - No ack is issued for the aborted access.
- WAIT_CYCLES = 0 gives ACCESS for exactly one cycle.
- cnt is 4 bits; values above 15 are illegal and a synthesis-time error.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration.
  - On a tie, the port that did not win the previous grant wins.
  - last_grant updates at every grant.
- DMEM_ARB_RR_EN undefined: fixed priority, CPU always wins a tie.
  - last_grant is not implemented.

## Structure
- Package dmem_arb_pkg holds:
  - the state encoding constants (IDLE, ACCESS, RESP);
  - the port ID constants (PORT_CPU = 0, PORT_LD = 1);
  - CNT_W = 4.
- One sub-module, dmem_arb_pick: combinational winner select from {cpu_req, ld_req, last_grant}.
  - The macro is handled inside dmem_arb_pick.

## Test plan
- **CPU write then read.** WAIT_CYCLES=1. Write 0xDEADBEEF to 0x40, then read 0x40.
  - o_DMem_we is high for exactly one cycle.
  - Each ack arrives 3 cycles after req is sampled.
  - The read returns o_cpu_rData = 0xDEADBEEF.
- **Stall tracking.** Hold i_cpu_req while the loader is mid-access.
  - o_cpu_stall stays high until the CPU ack cycle, then drops.
- **Simultaneous requests.** Both req high for 4 consecutive transactions.
  - RR_EN: grants alternate CPU, LD, CPU, LD.
  - Without RR_EN: CPU wins every tie while its req is held.
- **WAIT_CYCLES=0.** Back-to-back CPU reads of 0x0 then 0x4.
  - Acks are 3 cycles apart, with correct data each time.
- **Reset mid-ACCESS of a write.**
  - Assert rst in cycle T+1 with WAIT_CYCLES=2.
  - No ack, state returns to IDLE, memory contents unchanged at that address if rst hit before the strobe.
- **Input change after grant.** Change i_ld_addr during ACCESS.
  - The access completes at the originally latched address.
